// File: rtl/nucleic_acid_seq.sv
// Protocol sequencer: lysis -> wash -> elute mixing, then per-channel collection.
// Optional PUMP_REV_EN adds a pump_rev input selecting the reversed pump sequence.
module nucleic_acid_seq #(
  parameter int N_CH      = 4,
  parameter int STEP_W    = 8,
  parameter int PUMP_DIV  = 16,
  parameter int FILL_CYC  = 64,
  parameter int DRAIN_CYC = 64,
  parameter int COLL_CYC  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] lyse_steps,
  input  logic [STEP_W-1:0] wash_steps,
  input  logic [STEP_W-1:0] elute_steps,
  input  logic [N_CH-1:0]   chan_mask,
`ifdef PUMP_REV_EN
  input  logic              pump_rev,
`endif
  output logic              busy,
  output logic              done,
  output logic              lysis_ctl,
  output logic              wash_ctl,
  output logic              elute_ctl,
  output logic              vertical_ctl,
  output logic              loop_exit_ctl,
  output logic              bead_trap_ctl,
  output logic              waste_ctl,
  output logic [2:0]        pump,
  output logic [N_CH-1:0]   collect_ctl
);

  localparam int MAXA = (FILL_CYC > DRAIN_CYC) ? FILL_CYC : DRAIN_CYC;
  localparam int MAXB = (COLL_CYC > PUMP_DIV) ? COLL_CYC : PUMP_DIV;
  localparam int MAXC = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CW-1:0] FILL_END  = CW'(FILL_CYC - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(DRAIN_CYC - 1);
  localparam logic [CW-1:0] COLL_END  = CW'(COLL_CYC - 1);
  localparam logic [CW-1:0] DIV_END   = CW'(PUMP_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LYS_FILL, S_LYS_MIX, S_LYS_DRAIN,
    S_WSH_FILL, S_WSH_MIX, S_WSH_DRAIN,
    S_ELU_FILL, S_ELU_MIX,
    S_COLL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [2:0]        pidx_q, pidx_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic              rev_q, rev_d;
  logic [STEP_W-1:0] lyse_q, lyse_d;
  logic [STEP_W-1:0] wash_q, wash_d;
  logic [STEP_W-1:0] elute_q, elute_d;
  logic [N_CH-1:0]   mask_q, mask_d;

  logic [STEP_W-1:0] cur_steps;
  logic [CHW-1:0]    first_ch, nxt_ch;
  logic              nxt_found;
  state_e            elu_exit;
  logic              rev_in;

`ifdef PUMP_REV_EN
  assign rev_in = pump_rev;
`else
  assign rev_in = 1'b0;
`endif

  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) first_ch = CHW'(i);
      if (mask_q[i] && (CHW'(i) > ch_q)) begin
        nxt_found = 1'b1;
        nxt_ch    = CHW'(i);
      end
    end
  end

  always_comb begin
    unique case (state_q)
      S_LYS_FILL, S_LYS_MIX, S_LYS_DRAIN: cur_steps = lyse_q;
      S_WSH_FILL, S_WSH_MIX, S_WSH_DRAIN: cur_steps = wash_q;
      default:                            cur_steps = elute_q;
    endcase
    elu_exit = (|mask_q) ? S_COLL : S_DONE;
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    steps_d = steps_q;
    pidx_d  = pidx_q;
    ch_d    = ch_q;
    rev_d   = rev_q;
    lyse_d  = lyse_q;
    wash_d  = wash_q;
    elute_d = elute_q;
    mask_d  = mask_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LYS_FILL;
          cyc_d   = '0;
          lyse_d  = lyse_steps;
          wash_d  = wash_steps;
          elute_d = elute_steps;
          mask_d  = chan_mask;
        end
      end
      S_LYS_FILL, S_WSH_FILL, S_ELU_FILL: begin
        if (cyc_q == FILL_END) begin
          cyc_d = '0;
          if (cur_steps != '0) begin
            steps_d = cur_steps;
            pidx_d  = 3'd0;
            rev_d   = rev_in;
            unique case (state_q)
              S_LYS_FILL: state_d = S_LYS_MIX;
              S_WSH_FILL: state_d = S_WSH_MIX;
              default:    state_d = S_ELU_MIX;
            endcase
          end else begin
            unique case (state_q)
              S_LYS_FILL: state_d = S_LYS_DRAIN;
              S_WSH_FILL: state_d = S_WSH_DRAIN;
              default:    state_d = elu_exit;
            endcase
            ch_d = first_ch;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_LYS_MIX, S_WSH_MIX, S_ELU_MIX: begin
        if (cyc_q == DIV_END) begin
          cyc_d = '0;
          if (steps_q == STEP_W'(1)) begin
            ch_d = first_ch;
            unique case (state_q)
              S_LYS_MIX: state_d = S_LYS_DRAIN;
              S_WSH_MIX: state_d = S_WSH_DRAIN;
              default:   state_d = elu_exit;
            endcase
          end else begin
            steps_d = steps_q - STEP_W'(1);
            pidx_d  = (pidx_q == 3'd5) ? 3'd0 : pidx_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_LYS_DRAIN, S_WSH_DRAIN: begin
        if (cyc_q == DRAIN_END) begin
          cyc_d   = '0;
          state_d = (state_q == S_LYS_DRAIN) ? S_WSH_FILL : S_ELU_FILL;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_COLL: begin
        if (cyc_q == COLL_END) begin
          cyc_d = '0;
          if (nxt_found) ch_d = nxt_ch;
          else           state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cyc_d   = '0;
    end
  end

  function automatic logic [2:0] pump_code(input logic [2:0] idx,
                                           input logic       rev);
    logic [2:0] r;
    r = (rev && idx != 3'd0) ? 3'd6 - idx : idx;
    unique case (r)
      3'd0:    pump_code = 3'b110;
      3'd1:    pump_code = 3'b100;
      3'd2:    pump_code = 3'b101;
      3'd3:    pump_code = 3'b001;
      3'd4:    pump_code = 3'b011;
      default: pump_code = 3'b010;
    endcase
  endfunction

  logic            busy_d, done_d, lys_d, wsh_d, elu_d;
  logic            vert_d, loop_d, bead_d, waste_d;
  logic [2:0]      pump_d;
  logic [N_CH-1:0] coll_d;
  logic            busy_q, done_q, lys_q, wsh_q, elu_q;
  logic            vert_q, loop_q, bead_q, waste_q;
  logic [2:0]      pump_q;
  logic [N_CH-1:0] coll_q;

  always_comb begin
    busy_d  = !(state_q == S_IDLE || state_q == S_DONE);
    done_d  = (state_q == S_DONE);
    lys_d   = 1'b1;
    wsh_d   = 1'b1;
    elu_d   = 1'b1;
    vert_d  = 1'b1;
    loop_d  = 1'b1;
    bead_d  = 1'b1;
    waste_d = 1'b1;
    pump_d  = 3'b111;
    coll_d  = '1;
    unique case (state_q)
      S_LYS_FILL, S_WSH_FILL, S_ELU_FILL: begin
        vert_d = 1'b0;
        loop_d = 1'b0;
        if (state_q == S_LYS_FILL) lys_d = 1'b0;
        if (state_q == S_WSH_FILL) wsh_d = 1'b0;
        if (state_q == S_ELU_FILL) elu_d = 1'b0;
      end
      S_LYS_MIX, S_WSH_MIX, S_ELU_MIX: pump_d = pump_code(pidx_q, rev_q);
      S_LYS_DRAIN, S_WSH_DRAIN: begin
        loop_d  = 1'b0;
        waste_d = 1'b0;
      end
      S_COLL: begin
        loop_d       = 1'b0;
        bead_d       = 1'b0;
        coll_d[ch_q] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      steps_q <= '0;
      pidx_q  <= '0;
      ch_q    <= '0;
      rev_q   <= 1'b0;
      lyse_q  <= '0;
      wash_q  <= '0;
      elute_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      steps_q <= steps_d;
      pidx_q  <= pidx_d;
      ch_q    <= ch_d;
      rev_q   <= rev_d;
      lyse_q  <= lyse_d;
      wash_q  <= wash_d;
      elute_q <= elute_d;
      mask_q  <= mask_d;
    end
  end

  // Abort closes every valve on the same edge it forces IDLE.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lys_q   <= 1'b1;
      wsh_q   <= 1'b1;
      elu_q   <= 1'b1;
      vert_q  <= 1'b1;
      loop_q  <= 1'b1;
      bead_q  <= 1'b1;
      waste_q <= 1'b1;
      pump_q  <= 3'b111;
      coll_q  <= '1;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      lys_q   <= lys_d;
      wsh_q   <= wsh_d;
      elu_q   <= elu_d;
      vert_q  <= vert_d;
      loop_q  <= loop_d;
      bead_q  <= bead_d;
      waste_q <= waste_d;
      pump_q  <= pump_d;
      coll_q  <= coll_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lysis_ctl     = lys_q;
  assign wash_ctl      = wsh_q;
  assign elute_ctl     = elu_q;
  assign vertical_ctl  = vert_q;
  assign loop_exit_ctl = loop_q;
  assign bead_trap_ctl = bead_q;
  assign waste_ctl     = waste_q;
  assign pump          = pump_q;
  assign collect_ctl   = coll_q;

endmodule

// File: tb/tb_nucleic_acid_seq.sv
// Bench for nucleic_acid_seq: table of protocol runs checked cycle by cycle
// against a queue of expected output vectors, plus reset and abort sequences.
module tb_nucleic_acid_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] lyse_steps, wash_steps, elute_steps;
  logic [3:0] chan_mask;
  logic       pump_rev;
  logic       busy, done, lysis_ctl, wash_ctl, elute_ctl;
  logic       vertical_ctl, loop_exit_ctl, bead_trap_ctl, waste_ctl;
  logic [2:0] pump;
  logic [3:0] collect_ctl;

  always #5 clk = ~clk;

  nucleic_acid_seq #(
    .N_CH(4), .STEP_W(8), .PUMP_DIV(2),
    .FILL_CYC(4), .DRAIN_CYC(4), .COLL_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lyse_steps(lyse_steps), .wash_steps(wash_steps),
    .elute_steps(elute_steps), .chan_mask(chan_mask),
`ifdef PUMP_REV_EN
    .pump_rev(pump_rev),
`endif
    .busy(busy), .done(done), .lysis_ctl(lysis_ctl),
    .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
    .vertical_ctl(vertical_ctl), .loop_exit_ctl(loop_exit_ctl),
    .bead_trap_ctl(bead_trap_ctl), .waste_ctl(waste_ctl),
    .pump(pump), .collect_ctl(collect_ctl)
  );

  typedef struct {
    logic [7:0] l, w, e;
    logic [3:0] mask;
    int         exp_len;
  } cfg_t;

  logic [15:0] obs;
  assign obs = {busy, done, lysis_ctl, wash_ctl, elute_ctl, vertical_ctl,
                loop_exit_ctl, bead_trap_ctl, waste_ctl, pump, collect_ctl};

  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] fwd_t[6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  logic [2:0] rev_t[6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

  // Field order: busy, done, {lys,wsh,elu,vert,loop,bead,waste}, pump, collect
  function automatic logic [15:0] mk(input logic b, input logic d,
                                     input logic [6:0] v,
                                     input logic [2:0] p,
                                     input logic [3:0] c);
    return {b, d, v, p, c};
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_n(input logic [15:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic push_mix(input logic [7:0] n, input logic rev);
    for (int s = 0; s < int'(n); s++) begin
      logic [2:0] p;
      p = rev ? rev_t[s % 6] : fwd_t[s % 6];
      push_n(mk(1'b1, 1'b0, 7'b1111111, p, 4'hF), 2);
    end
  endtask

  task automatic push_run(input cfg_t c, input logic rev);
    push_n(mk(1'b1, 1'b0, 7'b0110011, 3'b111, 4'hF), 4);
    push_mix(c.l, rev);
    push_n(mk(1'b1, 1'b0, 7'b1111010, 3'b111, 4'hF), 4);
    push_n(mk(1'b1, 1'b0, 7'b1010011, 3'b111, 4'hF), 4);
    push_mix(c.w, rev);
    push_n(mk(1'b1, 1'b0, 7'b1111010, 3'b111, 4'hF), 4);
    push_n(mk(1'b1, 1'b0, 7'b1100011, 3'b111, 4'hF), 4);
    push_mix(c.e, rev);
    for (int i = 0; i < 4; i++)
      if (c.mask[i])
        push_n(mk(1'b1, 1'b0, 7'b1111001, 3'b111, ~(4'b0001 << i)), 4);
  endtask

  task automatic launch(input cfg_t c, input logic rev);
    lyse_steps  = c.l;
    wash_steps  = c.w;
    elute_steps = c.e;
    chan_mask   = c.mask;
    pump_rev    = rev;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    lyse_steps  = 8'hAA;
    wash_steps  = 8'h55;
    elute_steps = 8'hFF;
    chan_mask   = 4'h0;
  endtask

  // Pops and compares one expected vector per cycle. A one-cycle start pulse
  // mid-run must be ignored. abort_at >= 0 stops early with abort+start high.
  task automatic run_stream(input string name, input int abort_at,
                            output int busy_cnt);
    int w = 0;
    int idx = 0;
    busy_cnt = 0;
    while (!busy && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_busy_timeout: busy stayed %b", name, busy);
      exp_q.delete();
    end
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check(name, obs, e);
      if (busy) busy_cnt++;
      if (idx == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        exp_q.delete();
        @(negedge clk);
        return;
      end
      start = (busy_cnt == 10);
      idx++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  cfg_t tbl[6];
  int   bc;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{l: 8'd2, w: 8'd1, e: 8'd3, mask: 4'b1010, exp_len: 40};
    tbl[1] = '{l: 8'd2, w: 8'd0, e: 8'd3, mask: 4'b1010, exp_len: 38};
    tbl[2] = '{l: 8'd2, w: 8'd1, e: 8'd3, mask: 4'b0000, exp_len: 32};
    tbl[3] = '{l: 8'd1, w: 8'd1, e: 8'd1, mask: 4'b1111, exp_len: 42};
    tbl[4] = '{l: 8'd0, w: 8'd0, e: 8'd0, mask: 4'b0001, exp_len: 24};
    tbl[5] = '{l: 8'd7, w: 8'd2, e: 8'd1, mask: 4'b1000, exp_len: 44};

    rst = 1'b1; start = 1'b0; abort = 1'b0; pump_rev = 1'b0;
    lyse_steps = '0; wash_steps = '0; elute_steps = '0; chan_mask = '0;
    repeat (3) @(negedge clk);
    check("reset", obs, mk(1'b0, 1'b0, 7'h7F, 3'b111, 4'hF));
    rst = 1'b0;
    @(negedge clk);
    check("idle", obs, mk(1'b0, 1'b0, 7'h7F, 3'b111, 4'hF));

    for (int t = 0; t < 6; t++) begin
      push_run(tbl[t], 1'b0);
      launch(tbl[t], 1'b0);
      run_stream($sformatf("run%0d", t), -1, bc);
      check_int($sformatf("run%0d_len", t), bc, tbl[t].exp_len);
      check($sformatf("run%0d_done", t), obs,
            mk(1'b0, 1'b1, 7'h7F, 3'b111, 4'hF));
    end

    // Abort during elute mix together with start; start then accepted.
    push_run(tbl[0], 1'b0);
    launch(tbl[0], 1'b0);
    run_stream("abort_run", 28, bc);
    check("abort_idle", obs, mk(1'b0, 1'b0, 7'h7F, 3'b111, 4'hF));
    abort = 1'b0;
    lyse_steps = 8'd2; wash_steps = 8'd1; elute_steps = 8'd3;
    chan_mask = 4'b1010;
    @(negedge clk);
    start = 1'b0;
    check("abort_lag", obs, mk(1'b0, 1'b0, 7'h7F, 3'b111, 4'hF));
    @(negedge clk);
    check("abort_restart", obs, mk(1'b1, 1'b0, 7'b0110011, 3'b111, 4'hF));

    // Reset mid-run.
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_midrun", obs, mk(1'b0, 1'b0, 7'h7F, 3'b111, 4'hF));
    @(negedge clk);
    check("rst_stays_idle", obs, mk(1'b0, 1'b0, 7'h7F, 3'b111, 4'hF));

`ifdef PUMP_REV_EN
    begin
      cfg_t r;
      r = '{l: 8'd3, w: 8'd1, e: 8'd1, mask: 4'b0001, exp_len: 34};
      push_run(r, 1'b1);
      launch(r, 1'b1);
      run_stream("rev_run", -1, bc);
      check_int("rev_len", bc, r.exp_len);
      check("rev_done", obs, mk(1'b0, 1'b1, 7'h7F, 3'b111, 4'hF));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
